// File: rtl/product_accumulator_pkg.sv
// Shared definitions for the MAC datapath stages: FSM state encoding,
// default block geometry and the product width coming from the multiplier.
package product_accumulator_pkg;

    // Collect products while in RUN; present the finished sum while in DONE.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    // Default MAC datapath geometry.
    localparam int DEF_TERMS = 4;
    localparam int DEF_ACC_W = 12;

    // The upstream 4x4 array multiplier produces 8-bit unsigned products.
    localparam int PROD_W = 8;

    // Largest value representable by an ACC_W-bit unsigned accumulator.
    function automatic logic [63:0] acc_max(input int acc_w);
        return (64'd1 << acc_w) - 64'd1;
    endfunction

endpackage

// File: rtl/product_accumulator_sat_adder.sv
// Saturating unsigned adder: ACC_W-bit accumulator plus 8-bit product.
// Clamps to all-ones on carry-out and reports the overflow. It forms the
// combinational next-acc logic and is shared with later MAC stages.
module sat_adder
    import product_accumulator_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  result,
    output logic              overflow
);

    // One extra bit catches the carry out of the accumulator width.
    localparam int PAD = ACC_W + 1 - PROD_W;

    logic [ACC_W:0] wide_sum;

    // Widen both operands, add, and clamp on carry-out.
    always_comb begin
        wide_sum = {1'b0, acc} + {{PAD{1'b0}}, prod};
        overflow = wide_sum[ACC_W];
        result   = overflow ? {ACC_W{1'b1}} : wide_sum[ACC_W-1:0];
    end

endmodule

// File: rtl/product_accumulator.sv
// Sums blocks of TERMS 8-bit products into a saturating ACC_W-bit
// accumulator. The product input and the block-sum output each use a
// valid/ready handshake. A finished sum is held until the consumer accepts
// it. prod_ready depends only on registered state and clear, and sum_valid
// is the registered DONE state, so no combinational path runs from either
// valid input to the opposite ready output.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int TERMS = DEF_TERMS,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              prod_valid,
    output logic              prod_ready,
    output logic [ACC_W-1:0]  sum,
    output logic              sum_valid,
    input  logic              sum_ready,
    output logic              sat
);

    localparam int CNT_W = $clog2(TERMS + 1);

    state_t           state;
    state_t           next_state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] add_result;
    logic             add_ovf;
    logic [CNT_W-1:0] count;
    logic             sat_reg;
    logic             accept;
    logic             last_term;

    // A product transfers only when the handshake completes. The count
    // reaches TERMS-1 just before the final term of a block is accepted.
    assign accept    = prod_valid && prod_ready;
    assign last_term = (count == CNT_W'(TERMS - 1));

    sat_adder #(
        .ACC_W (ACC_W)
    ) u_sat_adder (
        .acc      (acc),
        .prod     (prod_in),
        .result   (add_result),
        .overflow (add_ovf)
    );

    // State register. Reset returns the block to collecting products.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= next_state;
        end
    end

    // Next state. clear overrides both the product and the sum handshakes.
    always_comb begin
        next_state = state;
        if (clear) begin
            next_state = ST_RUN;
        end else begin
            case (state)
                ST_RUN:  if (accept && last_term) next_state = ST_DONE;
                ST_DONE: if (sum_ready)           next_state = ST_RUN;
                default: next_state = ST_RUN;
            endcase
        end
    end

    // FSM outputs. These come from registered state and clear only.
    always_comb begin
        prod_ready = (state == ST_RUN) && !clear;
        sum_valid  = (state == ST_DONE);
    end

    // Accumulator, term counter and sticky saturation flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            count   <= '0;
            sat_reg <= 1'b0;
        end else if (clear) begin
            acc     <= '0;
            count   <= '0;
            sat_reg <= 1'b0;
        end else if (state == ST_DONE) begin
            // Hold the sum stable under back-pressure. Start fresh once it is taken.
            if (sum_ready) begin
                acc     <= '0;
                sat_reg <= 1'b0;
            end
        end else if (accept) begin
            acc     <= add_result;
            sat_reg <= sat_reg | add_ovf;
            count   <= last_term ? '0 : count + CNT_W'(1);
        end
    end

    assign sum = acc;
    assign sat = sat_reg;

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator. One stimulus stream drives a
// 12-bit instance and an 8-bit instance together, so that saturation occurs
// during the random phase. The driver keeps a block-level reference model
// and queues the expected sum for each completed block. A separate monitor
// compares every presented sum against the head of that queue.
module tb_product_accumulator;

    localparam int TERMS = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       prod_valid;
    logic       sum_ready;
    logic [7:0] prod_in;

    logic        prod_ready_a, sum_valid_a, sat_a;
    logic [11:0] sum_a;
    logic        prod_ready_b, sum_valid_b, sat_b;
    logic [7:0]  sum_b;

    always #5 clk = ~clk;

    product_accumulator #(.TERMS(TERMS), .ACC_W(12)) dut_a (
        .clk(clk), .rst(rst), .clear(clear), .prod_in(prod_in),
        .prod_valid(prod_valid), .prod_ready(prod_ready_a), .sum(sum_a),
        .sum_valid(sum_valid_a), .sum_ready(sum_ready), .sat(sat_a)
    );

    product_accumulator #(.TERMS(TERMS), .ACC_W(8)) dut_b (
        .clk(clk), .rst(rst), .clear(clear), .prod_in(prod_in),
        .prod_valid(prod_valid), .prod_ready(prod_ready_b), .sum(sum_b),
        .sum_valid(sum_valid_b), .sum_ready(sum_ready), .sat(sat_b)
    );

    typedef struct {
        longint s12;
        bit     sat12;
        longint s8;
        bit     sat8;
    } exp_t;

    exp_t   q[$];
    longint blk[$];
    bit     model_done = 1'b0;
    int     errors = 0;
    int     checks = 0;
    int     pushed = 0;
    int     discarded = 0;
    int     handshakes = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Block result from plain arithmetic: the total, clamped to the width.
    function automatic exp_t ref_block();
        exp_t   e;
        longint total = 0;
        foreach (blk[i]) total += blk[i];
        e.sat12 = total > 4095;
        e.s12   = e.sat12 ? 4095 : total;
        e.sat8  = total > 255;
        e.s8    = e.sat8 ? 255 : total;
        return e;
    endfunction

    // Run one clock cycle. Inputs are applied just after a rising edge, and
    // the model advances at the next rising edge.
    task automatic cycle(input bit v, input logic [7:0] p, input bit clr, input bit sr);
        prod_valid = v;
        prod_in    = p;
        clear      = clr;
        sum_ready  = sr;
        @(negedge clk);
        chk("prod_ready_a", prod_ready_a, !model_done && !clr);
        chk("prod_ready_b", prod_ready_b, !model_done && !clr);
        @(posedge clk);
        if (clr) begin
            blk.delete();
            if (model_done) begin
                q.delete(q.size() - 1);
                discarded++;
            end
            model_done = 1'b0;
        end else if (model_done) begin
            if (sr) model_done = 1'b0;
        end else if (v) begin
            blk.push_back(longint'(p));
            if (blk.size() == TERMS) begin
                q.push_back(ref_block());
                pushed++;
                blk.delete();
                model_done = 1'b1;
            end
        end
        #1;
    endtask

    // Monitor: while a sum is expected it must be presented and held stable.
    // Otherwise sum_valid must be low.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (q.size() > 0) begin
                    chk("sum_valid_a", sum_valid_a, 1);
                    chk("sum_valid_b", sum_valid_b, 1);
                    chk("sum_a", sum_a, q[0].s12);
                    chk("sat_a", sat_a, q[0].sat12);
                    chk("sum_b", sum_b, q[0].s8);
                    chk("sat_b", sat_b, q[0].sat8);
                    if (sum_ready && !clear) begin
                        q.delete(0);
                        handshakes++;
                    end
                end else begin
                    chk("sum_valid_idle_a", sum_valid_a, 0);
                    chk("sum_valid_idle_b", sum_valid_b, 0);
                end
            end
        end
    end

    initial begin
        int guard;
        rst = 1'b1; clear = 1'b0; prod_valid = 1'b0; sum_ready = 1'b0; prod_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_sum", sum_a, 0);
        chk("reset_valid", sum_valid_a, 0);
        chk("reset_sat", sat_a, 0);
        chk("reset_ready", prod_ready_a, 1);
        rst = 1'b0;

        // Four back-to-back products with the consumer always ready.
        repeat (4) cycle(1, 8'd225, 0, 1);
        cycle(0, 8'd0, 0, 1);
        cycle(0, 8'd0, 0, 1);

        // The same block under back-pressure, with a product offered during DONE.
        repeat (4) cycle(1, 8'd225, 0, 0);
        repeat (5) cycle(1, 8'h11, 0, 0);
        cycle(0, 8'd0, 0, 1);
        repeat (4) cycle(1, 8'd1, 0, 1);
        cycle(0, 8'd0, 0, 1);

        // Saturation on the 8-bit instance, then a clean block.
        cycle(1, 8'd200, 0, 1); cycle(1, 8'd100, 0, 1);
        cycle(1, 8'd5, 0, 1);   cycle(1, 8'd0, 0, 1);
        cycle(0, 8'd0, 0, 1);
        for (int i = 1; i <= 4; i++) cycle(1, 8'(i), 0, 1);
        cycle(0, 8'd0, 0, 1);

        // clear mid-block drops the offered product and the partial sum.
        cycle(1, 8'd7, 0, 1); cycle(1, 8'd9, 0, 1);
        cycle(1, 8'd50, 1, 1);
        for (int i = 1; i <= 4; i++) cycle(1, 8'(i), 0, 1);
        cycle(0, 8'd0, 0, 1);

        // Asynchronous reset between edges, with two terms taken.
        cycle(1, 8'd30, 0, 1); cycle(1, 8'd40, 0, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_sum", sum_a, 0);
        chk("async_rst_valid", sum_valid_a, 0);
        chk("async_rst_sat", sat_a, 0);
        blk.delete(); q.delete(); model_done = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) cycle(1, 8'd10, 0, 1);
        cycle(0, 8'd0, 0, 1);

        // Random bubbles, stalls and occasional clears over 100+ blocks.
        guard = 0;
        while (pushed < 110 && guard < 20000) begin
            cycle($urandom_range(1, 0) == 1, 8'($urandom_range(255, 0)),
                  $urandom_range(39, 0) == 0, $urandom_range(9, 0) < 6);
            guard++;
        end
        chk("random_budget", guard < 20000, 1);

        // Drain any pending sum and reconcile the block counts.
        guard = 0;
        while ((model_done || q.size() > 0) && guard < 20) begin
            cycle(0, 8'd0, 0, 1);
            guard++;
        end
        cycle(0, 8'd0, 0, 1);
        chk("queue_empty", q.size(), 0);
        chk("handshakes", handshakes, pushed - discarded);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
